// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter: FSM state
// enumeration, requester count, direction encoding and default widths.
// Optional feature macro (used by mem_arb_pick / mem_arbiter): MEM_ARB_RR_EN
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int   NUM_REQ    = 2;
    localparam logic RW_READ    = 1'b0;
    localparam logic RW_WRITE   = 1'b1;
    localparam int   DEF_ADDR_W = 5;
    localparam int   DEF_DATA_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the two requesters.
// Macro MEM_ARB_RR_EN: defined -> round-robin (the requester not granted most
// recently wins a tie); undefined -> fixed priority, requester 0 always wins.
//
// Ports:
//   i_req   [NUM_REQ-1:0]  per-requester request
//   i_last                 index of the most recently granted requester
//   o_any                  at least one request is present
//   o_win                  index of the winning requester (valid when o_any)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last,
    output logic               o_any,
    output logic               o_win
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        o_any = |i_req;
        // On a tie the requester that did not win last time goes next.
        if (&i_req) begin
            o_win = ~i_last;
        end else begin
            o_win = i_req[1];
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        o_any = |i_req;
        // Requester 1 only wins when requester 0 is silent.
        o_win = ~i_req[0];
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates two requesters onto a single-port memory. FSM IDLE -> ACCESS
// (-> RESP for reads) -> IDLE; all outputs are registered.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration; default
// build is fixed priority with requester 0 winning and no pointer register).
//
// Ports:
//   i_clk                       clock, rising edge
//   i_nRst                      synchronous active-low reset
//   i_req    [1:0]              per-requester request
//   i_rw     [1:0]              per-requester direction (0 read, 1 write)
//   i_addr   [2*ADDR_W-1:0]     per-requester address, slice r*ADDR_W
//   i_wData  [2*DATA_W-1:0]     per-requester write data, slice r*DATA_W
//   o_gnt    [1:0]              one-cycle grant pulse (during ACCESS)
//   o_rValid [1:0]              one-cycle read-valid pulse (during RESP)
//   o_rData  [DATA_W-1:0]       shared read data
//   o_busy                      high whenever not in IDLE
//   o_mem_sel                   memory select, high only during ACCESS
//   o_mem_rw                    memory direction
//   o_mem_addr  [ADDR_W-1:0]    memory address
//   o_mem_wData [DATA_W-1:0]    memory write data
//   i_mem_rData [DATA_W-1:0]    read data returned by the memory
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_nRst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_rw,
    input  logic [2*ADDR_W-1:0]   i_addr,
    input  logic [2*DATA_W-1:0]   i_wData,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_rValid,
    output logic [DATA_W-1:0]     o_rData,
    output logic                  o_busy,
    output logic                  o_mem_sel,
    output logic                  o_mem_rw,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wData,
    input  logic [DATA_W-1:0]     i_mem_rData
);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_rValid;
    logic [DATA_W-1:0]    r_rData;
    logic                 r_busy;
    logic                 r_mem_sel;
    logic                 r_mem_rw;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wData;
    logic                 r_win;

    logic                 w_any;
    logic                 w_win;
    logic                 w_last;

    mem_arb_pick u_pick (
        .i_req  (i_req),
        .i_last (w_last),
        .o_any  (w_any),
        .o_win  (w_win)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last;

    // Pointer starts as "last granted = 1" so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && w_any) begin
            r_last <= w_win;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rValid    <= '0;
            r_rData     <= '0;
            r_busy      <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wData <= '0;
            r_win       <= 1'b0;
        end else begin
            // Pulses default low; only the state that owns them raises them.
            r_gnt     <= '0;
            r_rValid  <= '0;
            r_mem_sel <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= ACCESS;
                        r_busy      <= 1'b1;
                        r_gnt       <= w_win ? 2'b10 : 2'b01;
                        r_mem_sel   <= 1'b1;
                        r_win       <= w_win;
                        r_mem_rw    <= w_win ? i_rw[1] : i_rw[0];
                        r_mem_addr  <= w_win ? i_addr[ADDR_W +: ADDR_W]
                                             : i_addr[0 +: ADDR_W];
                        r_mem_wData <= w_win ? i_wData[DATA_W +: DATA_W]
                                             : i_wData[0 +: DATA_W];
                    end
                end
                ACCESS: begin
                    if (r_mem_rw == RW_WRITE) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state  <= RESP;
                        r_rValid <= r_win ? 2'b10 : 2'b01;
                        r_rData  <= i_mem_rData;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_rValid    = r_rValid;
    assign o_rData     = r_rData;
    assign o_busy      = r_busy;
    assign o_mem_sel   = r_mem_sel;
    assign o_mem_rw    = r_mem_rw;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wData = r_mem_wData;

endmodule
